// File: rtl/ctrl_pipe_seq_pkg.sv
// Shared types for the LC-3b control pipeline: opcodes, ALU ops, the per-stage
// control word and the indirect-sequencer state encoding.
package ctrl_pipe_seq_pkg;

    typedef enum logic [3:0] {
        OpBr   = 4'h0,
        OpAdd  = 4'h1,
        OpLdb  = 4'h2,
        OpStb  = 4'h3,
        OpJsr  = 4'h4,
        OpAnd  = 4'h5,
        OpLdr  = 4'h6,
        OpStr  = 4'h7,
        OpRti  = 4'h8,
        OpNot  = 4'h9,
        OpLdi  = 4'hA,
        OpSti  = 4'hB,
        OpJmp  = 4'hC,
        OpShf  = 4'hD,
        OpLea  = 4'hE,
        OpTrap = 4'hF
    } lc3b_opcode_e;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef struct packed {
        logic [3:0] opcode;
        logic       valid;
        logic       ind_phase;
        lc3b_aluop  aluop;
        logic [2:0] alumux_sel;
        logic [2:0] pcmux_sel;
        logic       adjmux_sel;
        logic       destmux_sel;
        logic [2:0] regfilemux_sel;
        logic       regfile_load;
        logic       cc_load;
        logic       sr2mux_sel;
        logic       mem2_read;
        logic       mem2_write;
        logic [1:0] mem_mdrmux_sel;
        logic       memadd2mux_sel;
    } lc3b_ctrl_word;

    // No loads, reads or writes, ALU add, every select zero, not valid (a bubble).
    localparam lc3b_ctrl_word CTRL_DEFAULT = '{aluop: alu_add, default: '0};

    typedef logic [0:0] ctrl_state_t;
    localparam ctrl_state_t S_NORM = 1'b0;
    localparam ctrl_state_t S_IND2 = 1'b1;

    function automatic logic is_indirect_op(input logic [3:0] op);
        return (op == OpLdi) || (op == OpSti);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == OpRti) || (op == OpShf) || (op == OpStb) || (op == OpTrap);
    endfunction

endpackage

// File: rtl/ctrl_pipe_seq_decode.sv
// Combinational LC-3b decoder: (opcode, ir_bits, indirect phase) -> control word.
// phase_i selects the second micro-op of LDI/STI; other opcodes ignore it.
module ctrl_pipe_seq_decode
    import ctrl_pipe_seq_pkg::*;
(
    input  logic [3:0]    opcode_i,
    input  logic [11:0]   ir_bits_i,
    input  logic          phase_i,
    output lc3b_ctrl_word word_o
);

    logic unused_ir;
    assign unused_ir = ^{ir_bits_i[10:6], ir_bits_i[4:0]};

    // Start from the default word and set only the fields each opcode needs.
    always_comb begin
        word_o        = CTRL_DEFAULT;
        word_o.valid  = 1'b1;
        word_o.opcode = opcode_i;
        case (opcode_i)
            OpAdd, OpAnd: begin
                word_o.alumux_sel   = ir_bits_i[5] ? 3'b001 : 3'b100;
                word_o.regfile_load = 1'b1;
                word_o.cc_load      = 1'b1;
                if (opcode_i == OpAnd) word_o.aluop = alu_and;
            end
            OpNot: begin
                word_o.aluop        = alu_not;
                word_o.regfile_load = 1'b1;
                word_o.cc_load      = 1'b1;
            end
            OpBr: begin
                word_o.pcmux_sel = 3'b001;
            end
            OpJmp: begin
                word_o.pcmux_sel = 3'b010;
                word_o.aluop     = alu_pass;
            end
            OpJsr: begin
                word_o.destmux_sel    = 1'b1;
                word_o.regfilemux_sel = 3'b001;
                word_o.regfile_load   = 1'b1;
                if (ir_bits_i[11]) begin
                    word_o.pcmux_sel  = 3'b100;
                    word_o.adjmux_sel = 1'b1;
                end else begin
                    word_o.pcmux_sel  = 3'b010;
                    word_o.aluop      = alu_pass;
                end
            end
            OpLdr, OpLdb: begin
                word_o.mem2_read      = 1'b1;
                word_o.regfile_load   = 1'b1;
                word_o.cc_load        = 1'b1;
                word_o.mem_mdrmux_sel = 2'b01;
                if (opcode_i == OpLdb) begin
                    word_o.alumux_sel     = 3'b011;
                    word_o.mem_mdrmux_sel = 2'b10;
                end
            end
            OpStr: begin
                word_o.sr2mux_sel = 1'b1;
                word_o.mem2_write = 1'b1;
            end
            OpLea: begin
                word_o.regfile_load   = 1'b1;
                word_o.cc_load        = 1'b1;
                word_o.regfilemux_sel = 3'b010;
            end
            OpLdi, OpSti: begin
                if (!phase_i) begin
                    // Phase 1 fetches the pointer; nothing architectural is written.
                    word_o.mem2_read      = 1'b1;
                    word_o.mem_mdrmux_sel = 2'b01;
                end else begin
                    word_o.ind_phase      = 1'b1;
                    word_o.memadd2mux_sel = 1'b1;
                    if (opcode_i == OpLdi) begin
                        word_o.mem2_read    = 1'b1;
                        word_o.regfile_load = 1'b1;
                        word_o.cc_load      = 1'b1;
                    end else begin
                        word_o.sr2mux_sel = 1'b1;
                        word_o.mem2_write = 1'b1;
                    end
                end
            end
            default: begin
                // RTI/SHF/STB/TRAP: valid default word, flagged by the sequencer.
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_seq.sv
// LC-3b control pipeline: decodes the ID instruction, sequences LDI/STI as two
// memory micro-ops, and carries control words through NUM_STAGES registers with
// stall, flush and bubble insertion.
// Optional macro CTRL_PIPE_PERF_EN builds saturating stall/bubble counters;
// without it the perf ports read zero.
module ctrl_pipe_seq
    import ctrl_pipe_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned FLUSH_DEPTH = 2   // must not exceed NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [3:0]            opcode,
    input  logic [11:0]           ir_bits,
    input  logic                  stall,
    input  logic                  flush,
    output lc3b_ctrl_word         stage_ctrl [NUM_STAGES],
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  illegal_op,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bubble_cnt
);

    lc3b_ctrl_word stage_q [NUM_STAGES];
    lc3b_ctrl_word stage_d [NUM_STAGES];
    ctrl_state_t   state_q, state_d;
    logic          illegal_q, illegal_d;
    lc3b_ctrl_word dec_word;
    logic          emit;
    logic          ind_op;

    assign ind_op = is_indirect_op(opcode);

    // Phase 1 of LDI/STI does not consume the instruction; phase 2 does.
    assign id_ready = !stall && !flush && !(state_q == S_NORM && ind_op);

    ctrl_pipe_seq_decode u_decode (
        .opcode_i  (opcode),
        .ir_bits_i (ir_bits),
        .phase_i   (state_q == S_IND2),
        .word_o    (dec_word)
    );

    // Next state of the pipeline, sequencer and illegal flag.
    always_comb begin
        stage_d   = stage_q;
        state_d   = state_q;
        illegal_d = illegal_q;
        emit      = 1'b0;
        if (flush) begin
            // Squash the young stages, let older ones drain; ID is not consumed.
            stage_d[0] = CTRL_DEFAULT;
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                stage_d[i] = (i < FLUSH_DEPTH) ? CTRL_DEFAULT : stage_q[i-1];
            end
            state_d   = S_NORM;
            illegal_d = 1'b0;
        end else if (!stall) begin
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (state_q == S_IND2) begin
                emit    = 1'b1;
                state_d = S_NORM;
            end else if (id_valid) begin
                emit = 1'b1;
                if (ind_op) state_d = S_IND2;
            end
            stage_d[0] = emit ? dec_word : CTRL_DEFAULT;
            illegal_d  = emit && is_illegal_op(opcode);
        end
    end

    // Pipeline, sequencer and illegal flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= CTRL_DEFAULT;
            end
            state_q   <= S_NORM;
            illegal_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Drive per-stage outputs straight from the registers.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_ctrl[i]  = stage_q[i];
            stage_valid[i] = stage_q[i].valid;
        end
    end

    assign illegal_op = illegal_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; a flush cycle is not counted as a stall.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!stall && !flush && !stage_d[0].valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// Directed bench for ctrl_pipe_seq: hand-built expected control words checked
// with immediate assertions after each clock edge.
module tb_ctrl_pipe_seq;
    import ctrl_pipe_seq_pkg::*;

`ifdef CTRL_PIPE_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic          id_ready;
    logic [3:0]    opcode;
    logic [11:0]   ir_bits;
    logic          stall;
    logic          flush;
    lc3b_ctrl_word stage_ctrl [3];
    logic [2:0]    stage_valid;
    logic          illegal_op;
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    lc3b_ctrl_word w_add1, w_add2, w_ldi1, w_ldi2, w_sti1, w_sti2, w_jsr, w_ldb, w_trap;

    ctrl_pipe_seq dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .opcode          (opcode),
        .ir_bits         (ir_bits),
        .stall           (stall),
        .flush           (flush),
        .stage_ctrl      (stage_ctrl),
        .stage_valid     (stage_valid),
        .illegal_op      (illegal_op),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stages(input string tag, input lc3b_ctrl_word e0,
                                input lc3b_ctrl_word e1, input lc3b_ctrl_word e2);
        check({tag, "_s0"}, 64'(stage_ctrl[0]), 64'(e0));
        check({tag, "_s1"}, 64'(stage_ctrl[1]), 64'(e1));
        check({tag, "_s2"}, 64'(stage_ctrl[2]), 64'(e2));
    endtask

    initial begin
        // Expected words, built field by field; the all-zero word is the bubble.
        w_add1 = '0; w_add1.opcode = 4'h1; w_add1.valid = 1'b1;
        w_add1.alumux_sel = 3'b001; w_add1.regfile_load = 1'b1; w_add1.cc_load = 1'b1;
        w_add2 = w_add1; w_add2.alumux_sel = 3'b100;
        w_ldi1 = '0; w_ldi1.opcode = 4'hA; w_ldi1.valid = 1'b1;
        w_ldi1.mem2_read = 1'b1; w_ldi1.mem_mdrmux_sel = 2'b01;
        w_ldi2 = '0; w_ldi2.opcode = 4'hA; w_ldi2.valid = 1'b1; w_ldi2.ind_phase = 1'b1;
        w_ldi2.mem2_read = 1'b1; w_ldi2.memadd2mux_sel = 1'b1;
        w_ldi2.regfile_load = 1'b1; w_ldi2.cc_load = 1'b1;
        w_sti1 = w_ldi1; w_sti1.opcode = 4'hB;
        w_sti2 = '0; w_sti2.opcode = 4'hB; w_sti2.valid = 1'b1; w_sti2.ind_phase = 1'b1;
        w_sti2.sr2mux_sel = 1'b1; w_sti2.mem2_write = 1'b1; w_sti2.memadd2mux_sel = 1'b1;
        w_jsr = '0; w_jsr.opcode = 4'h4; w_jsr.valid = 1'b1; w_jsr.destmux_sel = 1'b1;
        w_jsr.regfilemux_sel = 3'b001; w_jsr.regfile_load = 1'b1;
        w_jsr.pcmux_sel = 3'b100; w_jsr.adjmux_sel = 1'b1;
        w_ldb = '0; w_ldb.opcode = 4'h2; w_ldb.valid = 1'b1; w_ldb.mem2_read = 1'b1;
        w_ldb.regfile_load = 1'b1; w_ldb.cc_load = 1'b1;
        w_ldb.alumux_sel = 3'b011; w_ldb.mem_mdrmux_sel = 2'b10;
        w_trap = '0; w_trap.opcode = 4'hF; w_trap.valid = 1'b1;

        // Reset then three idle cycles.
        reset = 1'b1; id_valid = 1'b0; opcode = 4'h0; ir_bits = 12'h000;
        stall = 1'b0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("idle_valid", 64'(stage_valid), 64'(3'b000));
        check_stages("idle", '0, '0, '0);
        check("idle_ready", 64'(id_ready), 64'(1'b1));
        check("idle_illegal", 64'(illegal_op), 64'(1'b0));

        // ADD immediate for one cycle, then follow it down the pipe.
        opcode = 4'h1; ir_bits = 12'h020; id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        check("add_s0", 64'(stage_ctrl[0]), 64'(w_add1));
        check("add_v0", 64'(stage_valid), 64'(3'b001));
        tick();
        check("add_v1", 64'(stage_valid), 64'(3'b010));
        tick();
        check_stages("add_at2", '0, '0, w_add1);

        // LDI: two micro-ops, then a register ADD enters right behind.
        opcode = 4'hA; ir_bits = 12'h000; id_valid = 1'b1;
        #1;
        check("ldi_rdy_p1", 64'(id_ready), 64'(1'b0));
        tick();
        check("ldi_p1", 64'(stage_ctrl[0]), 64'(w_ldi1));
        check("ldi_rdy_p2", 64'(id_ready), 64'(1'b1));
        tick();
        check_stages("ldi_p2", w_ldi2, w_ldi1, '0);
        opcode = 4'h1; ir_bits = 12'h000;
        tick();
        id_valid = 1'b0;
        check_stages("add2", w_add2, w_ldi2, w_ldi1);

        // STI with a four-cycle stall between the phases.
        opcode = 4'hB; id_valid = 1'b1;
        tick();
        check("sti_p1", 64'(stage_ctrl[0]), 64'(w_sti1));
        stall = 1'b1;
        #1;
        check("stall_rdy", 64'(id_ready), 64'(1'b0));
        tick(); tick(); tick(); tick();
        check_stages("stall_hold", w_sti1, w_add2, w_ldi2);
        check("stall_cnt", 64'(perf_stall_cnt), PerfEn ? 64'd4 : 64'd0);
        stall = 1'b0;
        #1;
        check("sti_rdy_p2", 64'(id_ready), 64'(1'b1));
        tick();
        check_stages("sti_p2", w_sti2, w_sti1, w_add2);
        check("bubble_cnt", 64'(perf_bubble_cnt), PerfEn ? 64'd5 : 64'd0);

        // Flush while LDI sits in S_IND2 with all three stages valid.
        opcode = 4'hA;
        tick();
        check_stages("pre_flush", w_ldi1, w_sti2, w_sti1);
        flush = 1'b1;
        #1;
        check("flush_rdy", 64'(id_ready), 64'(1'b0));
        tick();
        flush = 1'b0;
        check_stages("flushed", '0, '0, w_sti2);
        check("flush_illegal", 64'(illegal_op), 64'(1'b0));
        #1;
        check("reaccept_rdy", 64'(id_ready), 64'(1'b0));
        tick();
        check("reaccept_p1", 64'(stage_ctrl[0]), 64'(w_ldi1));
        tick();
        check("reaccept_p2", 64'(stage_ctrl[0]), 64'(w_ldi2));

        // JSR (offset form), LDB, then TRAP.
        opcode = 4'h4; ir_bits = 12'h800;
        tick();
        check("jsr", 64'(stage_ctrl[0]), 64'(w_jsr));
        opcode = 4'h2; ir_bits = 12'h000;
        tick();
        check("ldb", 64'(stage_ctrl[0]), 64'(w_ldb));
        opcode = 4'hF;
        tick();
        id_valid = 1'b0;
        check_stages("trap", w_trap, w_ldb, w_jsr);
        check("trap_ill", 64'(illegal_op), 64'(1'b1));
        tick();
        check("trap_ill_drop", 64'(illegal_op), 64'(1'b0));
        check("trap_v", 64'(stage_valid), 64'(3'b110));

        // ADD, then a stalled TRAP that must not enter, then reset under stall.
        opcode = 4'h1; ir_bits = 12'h020; id_valid = 1'b1;
        tick();
        opcode = 4'hF; stall = 1'b1;
        tick();
        check("stall_v", 64'(stage_valid), 64'(3'b101));
        check("stall_ill", 64'(illegal_op), 64'(1'b0));
        reset = 1'b1;
        tick();
        check("rst_stall_v", 64'(stage_valid), 64'(3'b000));
        check("rst_stall_s2", 64'(stage_ctrl[2]), 64'(lc3b_ctrl_word'('0)));
        check("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);

        // Reset in the middle of an LDI: sequence restarts at phase 1.
        reset = 1'b0; stall = 1'b0; opcode = 4'hA; ir_bits = 12'h000;
        tick();
        check("mid_p1", 64'(stage_ctrl[0]), 64'(w_ldi1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rdy", 64'(id_ready), 64'(1'b0));
        tick();
        check("mid_restart", 64'(stage_ctrl[0]), 64'(w_ldi1));
        id_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
